// File: rtl/pool2d_max_if.sv
// Pixel stream and parameter bundle for the 2x2 max-pool stage.
// The upstream side is the master; pool2d_max is the slave.
interface pool2d_max_if #(
    parameter int C_WIDTH = 9
);
    logic               param_ena;
    logic [C_WIDTH-1:0] param_width_in;
    logic [C_WIDTH-1:0] param_height_in;
    logic               param_relu;
    logic               pxl_ena_x;
    logic [31:0]        pxl_x;
    logic               pxl_ena_y;
    logic [31:0]        pxl_y;
    logic               frame_done;

    modport master (
        output param_ena, param_width_in, param_height_in, param_relu,
        output pxl_ena_x, pxl_x,
        input  pxl_ena_y, pxl_y, frame_done
    );

    modport slave (
        input  param_ena, param_width_in, param_height_in, param_relu,
        input  pxl_ena_x, pxl_x,
        output pxl_ena_y, pxl_y, frame_done
    );
endinterface

// File: rtl/pool2d_max.sv
// 2x2 stride-2 max-pool over a raster stream of IEEE-754 singles.
// One row buffer holds horizontal maxima of even rows; odd rows finish the 2x2 max.
module pool2d_max #(
    parameter int C_WIDTH   = 9,
    parameter int BUF_DEPTH = 256
) (
    input  logic         clk,
    input  logic         rst,
    pool2d_max_if.slave  bus
);
    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int HW = C_WIDTH - 1;

    // Map a float onto an unsigned key whose ordering matches the float ordering.
    function automatic logic [31:0] order_key(input logic [31:0] x);
        return x[31] ? ~x : (x ^ 32'h8000_0000);
    endfunction

    // Ties keep the first (earlier) operand.
    function automatic logic [31:0] fmax_keep_first(input logic [31:0] a, input logic [31:0] b);
        return (order_key(b) > order_key(a)) ? b : a;
    endfunction

    logic [C_WIDTH-1:0] width_reg;
    logic [C_WIDTH-1:0] height_reg;
    logic               relu_reg;
    logic [C_WIDTH-1:0] col_cnt_reg;
    logic [C_WIDTH-1:0] row_cnt_reg;
    logic [31:0]        h_hold_reg;
    logic               s1_valid_reg;
    logic               s1_last_reg;
    logic [31:0]        s1_hmax_reg;
    logic [31:0]        rd_data_reg;
    logic               y_valid_reg;
    logic               done_reg;
    logic [31:0]        y_reg;
    logic [31:0]        row_buf [BUF_DEPTH];

    logic               accept;
    logic               geom_ok;
    logic               col_last;
    logic               row_last;
    logic               pair_last;
    logic               buf_wr;
    logic               buf_rd;
    logic [AW-1:0]      buf_idx;
    logic [31:0]        hmax;
    logic [31:0]        vmax;
    logic [HW-1:0]      last_col_pair;
    logic [HW-1:0]      last_row_pair;

    assign accept   = bus.pxl_ena_x & ~bus.param_ena;
    assign geom_ok  = (width_reg >= C_WIDTH'(2)) && (height_reg >= C_WIDTH'(2));
    // Wider compare makes W=0 / H=0 behave as a single-entry wrap instead of overflowing.
    assign col_last = ({1'b0, col_cnt_reg} + (C_WIDTH+1)'(1)) >= {1'b0, width_reg};
    assign row_last = ({1'b0, row_cnt_reg} + (C_WIDTH+1)'(1)) >= {1'b0, height_reg};

    assign last_col_pair = width_reg[C_WIDTH-1:1]  - HW'(1);
    assign last_row_pair = height_reg[C_WIDTH-1:1] - HW'(1);
    assign pair_last     = (col_cnt_reg[C_WIDTH-1:1] == last_col_pair) &&
                           (row_cnt_reg[C_WIDTH-1:1] == last_row_pair);

    assign hmax    = fmax_keep_first(h_hold_reg, bus.pxl_x);
    assign vmax    = fmax_keep_first(rd_data_reg, s1_hmax_reg);
    assign buf_idx = AW'(col_cnt_reg >> 1);

    // A trailing even row of an odd-height frame is never buffered.
    assign buf_wr = accept & geom_ok & col_cnt_reg[0] & ~row_cnt_reg[0] & ~row_last;
    assign buf_rd = accept & geom_ok & col_cnt_reg[0] &  row_cnt_reg[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            width_reg    <= '0;
            height_reg   <= '0;
            relu_reg     <= 1'b0;
            col_cnt_reg  <= '0;
            row_cnt_reg  <= '0;
            h_hold_reg   <= '0;
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_hmax_reg  <= '0;
            y_valid_reg  <= 1'b0;
            done_reg     <= 1'b0;
            y_reg        <= '0;
        end else if (bus.param_ena) begin
            width_reg    <= bus.param_width_in;
            height_reg   <= bus.param_height_in;
            relu_reg     <= bus.param_relu;
            col_cnt_reg  <= '0;
            row_cnt_reg  <= '0;
            s1_valid_reg <= 1'b0;
            y_valid_reg  <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            if (accept) begin
                if (col_last) begin
                    col_cnt_reg <= '0;
                    row_cnt_reg <= row_last ? '0 : row_cnt_reg + C_WIDTH'(1);
                end else begin
                    col_cnt_reg <= col_cnt_reg + C_WIDTH'(1);
                end
                if (!col_cnt_reg[0]) begin
                    h_hold_reg <= bus.pxl_x;
                end
            end
            s1_valid_reg <= buf_rd;
            s1_last_reg  <= pair_last;
            s1_hmax_reg  <= hmax;

            y_valid_reg <= s1_valid_reg;
            done_reg    <= s1_valid_reg & s1_last_reg;
            if (s1_valid_reg) begin
                y_reg <= (relu_reg && vmax[31]) ? 32'h0000_0000 : vmax;
            end
        end
    end

    // Single-port row buffer with registered read; write and read are row-exclusive.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (buf_wr) begin
                row_buf[buf_idx] <= hmax;
            end else if (buf_rd) begin
                rd_data_reg <= row_buf[buf_idx];
            end
        end
    end

    assign bus.pxl_ena_y  = y_valid_reg;
    assign bus.frame_done = done_reg;
    assign bus.pxl_y      = y_reg;
endmodule
